// File: rtl/md_axil_master_if.sv
// AXI4-Lite bus bundle between md_axil_master and the control-register slave.
interface md_axil_master_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/md_axil_master.sv
// AXI4-Lite initiator: one register transaction per command, with optional masked polling.
// Define MD_AXIL_POLL_EN to compile in polling (GAP state, read counter, mask/match compare).
module md_axil_master #(
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_ADDR_WIDTH = 9,
    parameter int unsigned POLL_GAP        = 16,
    parameter int unsigned POLL_MAX        = 1024
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic                         cmd_poll,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_mask,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_match,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,
    md_axil_master_if.master             m_axil
);

    typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd, StGap, StRsp} state_e;

    state_e state_q, state_d;
    logic cmd_ready_q, cmd_ready_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [AXIL_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [1:0]                   rsp_resp_q, rsp_resp_d;

`ifdef MD_AXIL_POLL_EN
    localparam logic [15:0] PollMax   = 16'(POLL_MAX);
    localparam logic [15:0] PollGapM1 = 16'(POLL_GAP - 1);

    logic                       poll_q, poll_d;
    logic [AXIL_DATA_WIDTH-1:0] mask_q, mask_d, match_q, match_d;
    logic [15:0]                rd_cnt_q, rd_cnt_d, gap_cnt_q, gap_cnt_d;
    logic [15:0]                rd_cnt_inc;
    logic                       poll_hit;

    assign rd_cnt_inc = rd_cnt_q + 16'd1;
    assign poll_hit   = (m_axil.rdata & mask_q) == match_q;
`else
    logic unused_poll;
    assign unused_poll = ^{cmd_poll, cmd_mask, cmd_match};
`endif

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
`ifdef MD_AXIL_POLL_EN
        poll_d        = poll_q;
        mask_d        = mask_q;
        match_d       = match_q;
        rd_cnt_d      = rd_cnt_q;
        gap_cnt_d     = gap_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = {cmd_addr[AXIL_ADDR_WIDTH-1:2], 2'b00};
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
`ifdef MD_AXIL_POLL_EN
                    poll_d      = cmd_poll & ~cmd_write;
                    mask_d      = cmd_mask;
                    match_d     = cmd_match;
                    rd_cnt_d    = '0;
`endif
                    if (cmd_write) begin
                        state_d   = StWr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRa;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWr: begin
                if (m_axil.awready) awvalid_d = 1'b0;
                if (m_axil.wready)  wvalid_d  = 1'b0;
                // A channel whose valid is already low has completed earlier.
                if ((!awvalid_q || m_axil.awready) && (!wvalid_q || m_axil.wready)) begin
                    state_d  = StWb;
                    bready_d = 1'b1;
                end
            end
            StWb: begin
                if (m_axil.bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axil.bresp;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = StRsp;
                end
            end
            StRa: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRd;
                end
            end
            StRd: begin
                if (m_axil.rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_rdata_d   = m_axil.rdata;
                    rsp_resp_d    = m_axil.rresp;
                    rsp_timeout_d = 1'b0;
`ifdef MD_AXIL_POLL_EN
                    rd_cnt_d = rd_cnt_inc;
                    if (!poll_q || poll_hit || (m_axil.rresp != 2'b00) ||
                        (rd_cnt_inc == PollMax)) begin
                        state_d       = StRsp;
                        rsp_valid_d   = 1'b1;
                        // Only the exhausted-count exit leaves no match and an OKAY response.
                        rsp_timeout_d = poll_q && !poll_hit && (m_axil.rresp == 2'b00);
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = PollGapM1;
                    end
`else
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
`endif
                end
            end
`ifdef MD_AXIL_POLL_EN
            StGap: begin
                if (gap_cnt_q == '0) begin
                    arvalid_d = 1'b1;
                    state_d   = StRa;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
`endif
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
`ifdef MD_AXIL_POLL_EN
            poll_q        <= 1'b0;
            mask_q        <= '0;
            match_q       <= '0;
            rd_cnt_q      <= '0;
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
`ifdef MD_AXIL_POLL_EN
            poll_q        <= poll_d;
            mask_q        <= mask_d;
            match_q       <= match_d;
            rd_cnt_q      <= rd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_md_axil_master.sv
// Bench for md_axil_master: behavioural AXI4-Lite slave plus a response scoreboard.
module tb_md_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_poll = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0, cmd_mask = '0, cmd_match = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    md_axil_master_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) axil ();

    md_axil_master #(
        .AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(9), .POLL_GAP(16), .POLL_MAX(8)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_poll(cmd_poll), .cmd_mask(cmd_mask), .cmd_match(cmd_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil(axil.master)
    );

    always #5 clk = ~clk;

    // Slave model configuration and handshake counters
    int          aw_delay = 0, w_delay = 0, poll_set_at = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rd_val = '0;
    int          aw_wait = 0, w_wait = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
    logic        got_aw = 1'b0, got_w = 1'b0;

    assign axil.awready = axil.awvalid && (aw_wait >= aw_delay);
    assign axil.wready  = axil.wvalid && (w_wait >= w_delay);
    assign axil.arready = axil.arvalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
            axil.bvalid <= 1'b0; axil.bresp <= 2'b00;
            axil.rvalid <= 1'b0; axil.rresp <= 2'b00; axil.rdata <= '0;
        end else begin
            aw_wait <= (axil.awvalid && !axil.awready) ? aw_wait + 1 : 0;
            w_wait  <= (axil.wvalid && !axil.wready) ? w_wait + 1 : 0;
            if (axil.awvalid && axil.awready) begin got_aw <= 1'b1; aw_hs <= aw_hs + 1; end
            if (axil.wvalid && axil.wready) begin got_w <= 1'b1; w_hs <= w_hs + 1; end
            if ((got_aw || (axil.awvalid && axil.awready)) &&
                (got_w || (axil.wvalid && axil.wready)) && !axil.bvalid) begin
                axil.bvalid <= 1'b1; axil.bresp <= bresp_cfg;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (axil.bvalid && axil.bready) begin axil.bvalid <= 1'b0; b_hs <= b_hs + 1; end
            if (axil.arvalid && axil.arready) begin
                ar_hs <= ar_hs + 1;
                axil.rvalid <= 1'b1;
                axil.rresp <= rresp_cfg;
                axil.rdata <= (poll_set_at != 0 && ar_hs + 1 >= poll_set_at) ? (rd_val | 32'h2)
                                                                              : rd_val;
            end
            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0;

    task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp, input logic to);
        exp_q.push_back('{rdata: rdata, resp: resp, timeout: to});
    endtask

    // Returns one time unit after the accepting edge (start of cycle 1).
    task automatic send_cmd(input string name, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic poll,
                            input logic [31:0] mask, input logic [31:0] match);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_wstrb = 4'hf; cmd_poll = poll; cmd_mask = mask; cmd_match = match;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL %s accept: cmd_ready=%b required 1 within 100 cycles", name, cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // Scoreboard consumer: pops the expected response and checks it, holding for a few cycles.
    task automatic collect_rsp(input string name, input int hold);
        exp_t e;
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (rsp_valid !== 1'b1) begin
            n_checks++;
            $display("FAIL %s rsp_valid: got %b required 1 within 2000 cycles", name, rsp_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s unexpected response rdata=%h", name, rsp_rdata);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (rsp_rdata !== e.rdata)
                $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, e.rdata);
            else n_pass++;
            n_checks++;
            if (rsp_resp !== e.resp)
                $display("FAIL %s resp: got %0d required %0d", name, rsp_resp, e.resp);
            else n_pass++;
            n_checks++;
            if (rsp_timeout !== e.timeout)
                $display("FAIL %s timeout: got %b required %b", name, rsp_timeout, e.timeout);
            else n_pass++;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                n_checks++;
                if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !==
                    {1'b1, e.rdata, e.resp, e.timeout})
                    $display("FAIL %s hold%0d: got v=%b d=%h r=%0d t=%b", name, i,
                             rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
                else n_pass++;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL %s rsp_valid after handshake: got %b required 0",
                                         name, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready,
             rsp_valid, rsp_timeout} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000", {cmd_ready, axil.awvalid,
                     axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp_valid, rsp_timeout});
        else n_pass++;
        n_checks++;
        if ({axil.awaddr, axil.araddr, axil.wdata, axil.wstrb, rsp_rdata, rsp_resp} !== '0)
            $display("FAIL reset_data: got aw=%h ar=%h wd=%h rd=%h", axil.awaddr, axil.araddr,
                     axil.wdata, rsp_rdata);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_release: cmd_ready got %b required 0",
                                         cmd_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_first_edge: cmd_ready got %b required 1",
                                         cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_zero_wait();
        int b0 = b_hs;
        push_exp(32'h0, 2'b00, 1'b0);
        send_cmd("wr0", 1'b1, 9'h010, 32'h5, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({axil.awvalid, axil.wvalid, axil.awaddr, axil.wdata, axil.wstrb} !==
            {2'b11, 9'h010, 32'h5, 4'hf})
            $display("FAIL wr0_cycle1: got aw=%b w=%b addr=%h data=%h", axil.awvalid,
                     axil.wvalid, axil.awaddr, axil.wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b001)
            $display("FAIL wr0_cycle2: got aw/w/b=%b required 001",
                     {axil.awvalid, axil.wvalid, axil.bready});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, axil.bready} !== 2'b10)
            $display("FAIL wr0_cycle3: got rsp_valid/bready=%b required 10",
                     {rsp_valid, axil.bready});
        else n_pass++;
        collect_rsp("wr0", 0);
        n_checks++;
        if (b_hs - b0 !== 1) $display("FAIL wr0_bcount: got %0d required 1", b_hs - b0);
        else n_pass++;
    endtask

    task automatic test_write_aw_delay();
        int b0 = b_hs, a0 = aw_hs;
        logic [1:0] ev;
        aw_delay = 3; bresp_cfg = 2'b01;
        push_exp(32'h0, 2'b01, 1'b0);
        send_cmd("wr_awdly", 1'b1, 9'h013, 32'hCAFE_0001, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ev = {1'(c <= 4), 1'(c == 1)};
            n_checks++;
            if ({axil.awvalid, axil.wvalid} !== ev)
                $display("FAIL wr_awdly_cycle%0d: got aw/w=%b required %b", c,
                         {axil.awvalid, axil.wvalid}, ev);
            else n_pass++;
        end
        collect_rsp("wr_awdly", 2);
        n_checks++;
        if ({b_hs - b0, aw_hs - a0} !== {32'd1, 32'd1})
            $display("FAIL wr_awdly_hs: got b=%0d aw=%0d required 1/1", b_hs - b0, aw_hs - a0);
        else n_pass++;
        n_checks++;
        if (axil.awaddr !== 9'h010) $display("FAIL wr_awdly_addr: got %h required 010",
                                             axil.awaddr);
        else n_pass++;
        aw_delay = 0; bresp_cfg = 2'b00;
    endtask

    task automatic test_read();
        rd_val = 32'hDEAD_BEEF; rresp_cfg = 2'b10;
        push_exp(32'hDEAD_BEEF, 2'b10, 1'b0);
        send_cmd("rd", 1'b0, 9'h020, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({axil.arvalid, axil.rready, axil.araddr} !== {2'b10, 9'h020})
            $display("FAIL rd_cycle1: got ar=%b r=%b addr=%h", axil.arvalid, axil.rready,
                     axil.araddr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({axil.arvalid, axil.rready} !== 2'b01)
            $display("FAIL rd_cycle2: got ar/r=%b required 01", {axil.arvalid, axil.rready});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL rd_cycle3: rsp_valid got %b required 1",
                                         rsp_valid);
        else n_pass++;
        collect_rsp("rd", 3);
        rresp_cfg = 2'b00;
    endtask

    task automatic test_poll();
        int a0 = ar_hs;
        int c = 0;
        rd_val = 32'h1;
        poll_set_at = ar_hs + 4;
`ifdef MD_AXIL_POLL_EN
        push_exp(32'h3, 2'b00, 1'b0);
`else
        push_exp(32'h1, 2'b00, 1'b0);
`endif
        send_cmd("poll", 1'b0, 9'h000, 32'h0, 1'b1, 32'h2, 32'h2);
        while (rsp_valid !== 1'b1 && c < 500) begin @(negedge clk); c++; end
`ifdef MD_AXIL_POLL_EN
        n_checks++;
        if (c !== 57) $display("FAIL poll_latency: got cycle %0d required 57", c);
        else n_pass++;
`else
        n_checks++;
        if (c !== 3) $display("FAIL poll_latency: got cycle %0d required 3", c);
        else n_pass++;
`endif
        collect_rsp("poll", 0);
        n_checks++;
`ifdef MD_AXIL_POLL_EN
        if (ar_hs - a0 !== 4) $display("FAIL poll_reads: got %0d required 4", ar_hs - a0);
`else
        if (ar_hs - a0 !== 1) $display("FAIL poll_reads: got %0d required 1", ar_hs - a0);
`endif
        else n_pass++;
        poll_set_at = 0;
    endtask

    task automatic test_poll_timeout();
        int a0 = ar_hs;
        rd_val = 32'h10;
`ifdef MD_AXIL_POLL_EN
        push_exp(32'h10, 2'b00, 1'b1);
`else
        push_exp(32'h10, 2'b00, 1'b0);
`endif
        send_cmd("poll_to", 1'b0, 9'h004, 32'h0, 1'b1, 32'h2, 32'h2);
        collect_rsp("poll_to", 1);
        n_checks++;
`ifdef MD_AXIL_POLL_EN
        if (ar_hs - a0 !== 8) $display("FAIL poll_to_reads: got %0d required 8", ar_hs - a0);
`else
        if (ar_hs - a0 !== 1) $display("FAIL poll_to_reads: got %0d required 1", ar_hs - a0);
`endif
        else n_pass++;
        // An error response ends a poll after one beat.
        a0 = ar_hs; rresp_cfg = 2'b11;
        push_exp(32'h10, 2'b11, 1'b0);
        send_cmd("poll_err", 1'b0, 9'h004, 32'h0, 1'b1, 32'h2, 32'h2);
        collect_rsp("poll_err", 0);
        n_checks++;
        if (ar_hs - a0 !== 1) $display("FAIL poll_err_reads: got %0d required 1", ar_hs - a0);
        else n_pass++;
        rresp_cfg = 2'b00;
    endtask

    task automatic test_back_to_back();
        push_exp(32'h0, 2'b00, 1'b0);
        send_cmd("b2b_wr", 1'b1, 9'h008, 32'h1234, 1'b0, 32'h0, 32'h0);
        collect_rsp("b2b_wr", 0);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: cmd_ready got %b required 1",
                                         cmd_ready);
        else n_pass++;
        rd_val = 32'h0BAD_F00D;
        push_exp(32'h0BAD_F00D, 2'b00, 1'b0);
        send_cmd("b2b_rd", 1'b0, 9'h00c, 32'h0, 1'b0, 32'h0, 32'h0);
        collect_rsp("b2b_rd", 0);
    endtask

    task automatic test_reset_mid();
        aw_delay = 20; w_delay = 20;
        send_cmd("rst_mid", 1'b1, 9'h018, 32'h7777, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (axil.wvalid !== 1'b1) $display("FAIL rst_mid_pre: wvalid got %b required 1",
                                           axil.wvalid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready,
             rsp_valid, rsp_timeout, axil.awaddr, axil.wdata, rsp_rdata, rsp_resp} !== '0)
            $display("FAIL rst_mid_outputs: got aw=%b w=%b addr=%h data=%h", axil.awvalid,
                     axil.wvalid, axil.awaddr, axil.wdata);
        else n_pass++;
        @(negedge clk);
        aw_delay = 0; w_delay = 0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_mid_release: cmd_ready got %b required 1",
                                         cmd_ready);
        else n_pass++;
        rd_val = 32'h1234_5678;
        push_exp(32'h1234_5678, 2'b00, 1'b0);
        send_cmd("rst_mid_rd", 1'b0, 9'h1fc, 32'h0, 1'b0, 32'h0, 32'h0);
        collect_rsp("rst_mid_rd", 0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read();
        test_poll();
        test_poll_timeout();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d responses missing",
                                        exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
